// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared types for the register-file writeback scheduler
package regfile_wb_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regsel_t;
  typedef logic [31:0] regbits_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

  typedef struct packed {
    regsel_t wsel;
    word_t   wdat;
  } wb_entry_t;

  localparam int NUM_REGS = 32;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular writeback entry FIFO with registered head
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Readiness is a function of count alone, so a full FIFO refuses a push even while popping.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - round-robin writeback port sharing with RAW scoreboard
module regfile_wb_scheduler
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_wsel,
  input  logic [31:0] alu_wdat,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_wsel,
  input  logic [31:0] mem_wdat,
  input  logic        claim_en,
  input  logic [4:0]  claim_sel,
  output logic [31:0] pending,
  output logic        WEN,
  output logic [4:0]  wsel,
  output logic [31:0] wdat
);

  wb_entry_t alu_head, mem_head, grant_head;
  logic      alu_full, alu_empty, mem_full, mem_empty;
  logic      grant_alu, grant_mem, grant;
  src_t      rr_last_q, rr_last_d;
  regbits_t  pending_q, pending_d;

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .push       (alu_valid),
    .push_entry ('{wsel: alu_wsel, wdat: alu_wdat}),
    .pop        (grant_alu),
    .full       (alu_full),
    .empty      (alu_empty),
    .head       (alu_head)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .push       (mem_valid),
    .push_entry ('{wsel: mem_wsel, wdat: mem_wdat}),
    .pop        (grant_mem),
    .full       (mem_full),
    .empty      (mem_empty),
    .head       (mem_head)
  );

  assign alu_ready = !alu_full;
  assign mem_ready = !mem_full;
  assign pending   = pending_q;

  // When both heads are valid, the source that did not win last time takes the port.
  always_comb begin
    grant_alu  = !alu_empty && (mem_empty || rr_last_q == SRC_MEM);
    grant_mem  = !mem_empty && (alu_empty || rr_last_q == SRC_ALU);
    grant      = grant_alu || grant_mem;
    grant_head = '0;
    if (grant_alu) begin
      grant_head = alu_head;
    end else if (grant_mem) begin
      grant_head = mem_head;
    end
    rr_last_d = rr_last_q;
    if (grant_alu) begin
      rr_last_d = SRC_ALU;
    end else if (grant_mem) begin
      rr_last_d = SRC_MEM;
    end
  end

  assign WEN  = grant && (grant_head.wsel != '0);
  assign wsel = grant_head.wsel;
  assign wdat = grant_head.wdat;

  // A same-cycle claim means a newer producer is in flight, so set beats clear.
  always_comb begin
    pending_d = pending_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (claim_en && claim_sel == 5'(r)) begin
        pending_d[r] = 1'b1;
      end else if (grant && grant_head.wsel == 5'(r)) begin
        pending_d[r] = 1'b0;
      end
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_last_q <= SRC_MEM;
      pending_q <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      pending_q <= pending_d;
    end
  end

endmodule
